// File: rtl/q_add_arbiter.sv
// Round-robin arbiter in front of one shared saturating adder with a one-deep result register.
// Data width and clamp limits come from the FIXED_* defines (include.vh); defaults below give a 16-bit build.
`ifndef FIXED_WIDTH
`define FIXED_WIDTH 16
`endif
`ifndef FIXED_MAX
`define FIXED_MAX 16'h7FFF
`endif
`ifndef FIXED_MIN
`define FIXED_MIN 16'h8000
`endif

module q_add_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*`FIXED_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*`FIXED_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              resp_valid,
    input  logic                              resp_ready,
    output logic [`FIXED_WIDTH-1:0]           resp_data,
    output logic [$clog2(NUM_REQ)-1:0]        resp_id,
    output logic                              resp_sat,
    input  logic                              clr_stats,
    output logic [15:0]                       sat_count
);
    localparam int W   = `FIXED_WIDTH;
    localparam int IDW = $clog2(NUM_REQ);
    localparam logic signed [W-1:0]   SMAX    = `FIXED_MAX;
    localparam logic signed [W-1:0]   SMIN    = `FIXED_MIN;
    localparam logic signed [2*W-1:0] MAX_EXT = {{W{SMAX[W-1]}}, SMAX};
    localparam logic signed [2*W-1:0] MIN_EXT = {{W{SMIN[W-1]}}, SMIN};

    logic                   r_resp_valid;
    logic [W-1:0]           r_resp_data;
    logic [IDW-1:0]         r_resp_id;
    logic                   r_resp_sat;
    logic [IDW-1:0]         r_rr_ptr;
    logic [15:0]            r_sat_count;

    logic                   w_slot_free;
    logic                   w_found;
    logic                   w_accept;
    logic [IDW-1:0]         w_gidx;
    logic [IDW-1:0]         w_rr_next;
    logic [W-1:0]           w_a;
    logic [W-1:0]           w_b;
    logic signed [2*W-1:0]  w_sum;
    logic [W-1:0]           w_res;
    logic                   w_sat;

    assign w_slot_free = !r_resp_valid || resp_ready;

    // Grant search depends only on req_valid and state, never on operand data.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            int j;
            j = int'(r_rr_ptr) + off;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_found && req_valid[j]) begin
                w_found = 1'b1;
                w_gidx  = IDW'(j);
            end
        end
    end

    assign w_accept  = w_slot_free && w_found && !rst;
    assign w_rr_next = (w_gidx == IDW'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_gidx] = 1'b1;
    end

    assign w_a   = req_a[w_gidx*W +: W];
    assign w_b   = req_b[w_gidx*W +: W];
    assign w_sum = {{W{w_a[W-1]}}, w_a} + {{W{w_b[W-1]}}, w_b};

    always_comb begin
        w_res = w_sum[W-1:0];
        w_sat = 1'b0;
        if (w_sum > MAX_EXT) begin
            w_res = SMAX;
            w_sat = 1'b1;
        end else if (w_sum < MIN_EXT) begin
            w_res = SMIN;
            w_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
            r_resp_sat   <= 1'b0;
            r_rr_ptr     <= '0;
        end else if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_res;
            r_resp_id    <= w_gidx;
            r_resp_sat   <= w_sat;
            r_rr_ptr     <= w_rr_next;
        end else if (r_resp_valid && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    // Clear wins over a same-cycle increment; the counter sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_count <= '0;
        end else if (clr_stats) begin
            r_sat_count <= '0;
        end else if (w_accept && w_sat && (r_sat_count != 16'hFFFF)) begin
            r_sat_count <= r_sat_count + 16'd1;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;
    assign resp_sat   = r_resp_sat;
    assign sat_count  = r_sat_count;

endmodule

// File: tb/tb_q_add_arbiter.sv
// Scoreboard bench for q_add_arbiter (NUM_REQ=4, 16-bit data): stimulus pushes expected
// results, a negedge monitor pops and compares on every response handshake.
module tb_q_add_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [1:0]  resp_id;
    logic        resp_sat;
    logic        clr_stats;
    logic [15:0] sat_count;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  id;
        logic        s;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    q_add_arbiter #(.NUM_REQ(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_id(resp_id), .resp_sat(resp_sat),
        .clr_stats(clr_stats), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [1:0] id, input logic s);
        exp_t e;
        e.d = d; e.id = id; e.s = s;
        q.push_back(e);
    endtask

    // Called at posedge+1 with resp_ready high; returns at posedge+1 of the next cycle.
    task automatic issue_one(input int k, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] ed, input logic es);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        req_valid = oh;
        req_a = '0;
        req_b = '0;
        req_a[k*16 +: 16] = a;
        req_b[k*16 +: 16] = b;
        #1 chk("grant_one", 32'(req_ready), 32'(oh));
        push(ed, 2'(k), es);
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic set_rr_operands();
        for (int i = 0; i < 4; i++) begin
            req_a[i*16 +: 16] = 16'(i * 16);
            req_b[i*16 +: 16] = 16'h0001;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp act=%h exp=none", resp_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_data", 32'(resp_data), 32'(e.d));
                chk("resp_id",   32'(resp_id),   32'(e.id));
                chk("resp_sat",  32'(resp_sat),  32'(e.s));
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0;
        resp_ready = 1'b1; clr_stats = 1'b0;
        #2;
        chk("rst_valid",     32'(resp_valid), 0);
        chk("rst_data",      32'(resp_data),  0);
        chk("rst_id",        32'(resp_id),    0);
        chk("rst_sat",       32'(resp_sat),   0);
        chk("rst_satcount",  32'(sat_count),  0);
        chk("rst_req_ready", 32'(req_ready),  0);
        req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single request, accepted on the first edge after reset.
        issue_one(0, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        chk("lat_valid", 32'(resp_valid), 1);

        // Saturation both ways plus exact-limit and wrap-to-zero non-saturating sums.
        issue_one(1, 16'h7000, 16'h2000, 16'h7FFF, 1'b1);
        chk("satcnt_1", 32'(sat_count), 1);
        issue_one(2, 16'h8000, 16'hFFFF, 16'h8000, 1'b1);
        chk("satcnt_2", 32'(sat_count), 2);
        issue_one(0, 16'h7FFF, 16'h0000, 16'h7FFF, 1'b0);
        issue_one(3, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
        chk("satcnt_hold", 32'(sat_count), 2);

        // Round-robin with all requesters held: ids 0,1,2,3,0 one per cycle.
        req_valid = 4'b1111;
        set_rr_operands();
        for (int c = 0; c < 5; c++) begin
            #1 chk("rr_grant", 32'(req_ready), 32'(4'b0001 << (c % 4)));
            push(16'((c % 4) * 16 + 1), 2'(c % 4), 1'b0);
            @(posedge clk); #1;
        end
        req_valid = '0;

        // Backpressure with 0x0300 pending from requester 1.
        issue_one(1, 16'h0100, 16'h0200, 16'h0300, 1'b0);
        resp_ready = 1'b0;
        req_valid = 4'b1111;
        set_rr_operands();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready),  0);
            chk("bp_valid",     32'(resp_valid), 1);
            chk("bp_data",      32'(resp_data),  32'h0300);
            chk("bp_id",        32'(resp_id),    1);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        #1 chk("bp_release_grant", 32'(req_ready), 32'(4'b0100));
        push(16'h0021, 2'd2, 1'b0);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // Reset while a saturated result is pending and unconsumed.
        resp_ready = 1'b0;
        req_valid = 4'b0001;
        req_a = '0; req_b = '0;
        req_a[15:0] = 16'h7000; req_b[15:0] = 16'h2000;
        @(posedge clk); #1;
        req_valid = '0;
        chk("pend_valid",  32'(resp_valid), 1);
        chk("pend_satcnt", 32'(sat_count),  3);
        rst = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("midrst_valid",     32'(resp_valid), 0);
        chk("midrst_satcnt",    32'(sat_count),  0);
        chk("midrst_data",      32'(resp_data),  0);
        chk("midrst_req_ready", 32'(req_ready),  0);
        @(posedge clk); #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        req_a = '0; req_b = '0;
        req_a[63:48] = 16'h0005; req_b[63:48] = 16'h0003;
        #1 chk("post_rst_grant", 32'(req_ready), 32'(4'b1000));
        push(16'h0008, 2'd3, 1'b0);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;

        // Stats: saturate past 0xFFFF, then clear alongside a saturating op.
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        req_valid = 4'b0001;
        req_a = '0; req_b = '0;
        req_a[15:0] = 16'h7FFF; req_b[15:0] = 16'h7FFF;
        for (int i = 0; i < 65540; i++) begin
            push(16'h7FFF, 2'd0, 1'b1);
            @(posedge clk); #1;
            if (i == 65533) chk("satcnt_fffe", 32'(sat_count), 32'hFFFE);
        end
        chk("satcnt_stick", 32'(sat_count), 32'hFFFF);
        clr_stats = 1'b1;
        push(16'h7FFF, 2'd0, 1'b1);
        @(posedge clk); #1;
        clr_stats = 1'b0;
        req_valid = '0;
        chk("satcnt_clr_prio", 32'(sat_count), 0);

        repeat (3) @(posedge clk);
        #1 chk("queue_empty", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
